// File: rtl/npc_pkg.sv
// Shared definitions for the NPC core write-back/commit slice: data widths,
// the halt-triggering ebreak encoding and the commit FSM state type.
package npc_pkg;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

    // Width of the flattened architectural register image seen by the DPI model
    localparam int RF_FLAT_W = NREG * XLEN;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } commit_state_e;

endpackage

// File: rtl/wb_commit_rf_if.sv
// Retire handshake between the upstream pipeline and the write-back stage.
// Handshake: a transfer ("fire") happens on a rising clk edge where
// wb_valid and wb_ready are both 1; payload is only meaningful while
// wb_valid is 1, and wb_ready may drop independently of wb_valid.
interface wb_commit_rf_if
    import npc_pkg::*;
();

    logic            wb_valid;
    logic            wb_ready;
    logic [XLEN-1:0] wb_pc;
    logic [31:0]     wb_inst;
    logic            wb_wen;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_wdata;

    // Upstream pipeline side
    modport master (
        output wb_valid, wb_pc, wb_inst, wb_wen, wb_rd, wb_wdata,
        input  wb_ready
    );

    // Write-back stage side
    modport slave (
        input  wb_valid, wb_pc, wb_inst, wb_wen, wb_rd, wb_wdata,
        output wb_ready
    );

endinterface

// File: rtl/rf_2r1w.sv
// 32x64 architectural register file: two combinational read ports with
// write-first bypass, one synchronous write port, x0 tied to zero, and a
// flattened view of the registered state.
module rf_2r1w
    import npc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_wen,
    input  logic [4:0]           i_waddr,
    input  logic [XLEN-1:0]      i_wdata,
    input  logic [4:0]           i_raddr1,
    input  logic [4:0]           i_raddr2,
    output logic [XLEN-1:0]      o_rdata1,
    output logic [XLEN-1:0]      o_rdata2,
    output logic [RF_FLAT_W-1:0] o_flat
);

    logic [XLEN-1:0] r_regs [NREG];

    // Register array update; x0 is never written so it stays at its reset zero
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_wen && (i_waddr != 5'd0)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // Read ports: x0 reads zero, a same-cycle write to the index is forwarded
    always_comb begin
        o_rdata1 = '0;
        o_rdata2 = '0;
        if (i_raddr1 != 5'd0) begin
            o_rdata1 = (i_wen && (i_waddr == i_raddr1)) ? i_wdata : r_regs[i_raddr1];
        end
        if (i_raddr2 != 5'd0) begin
            o_rdata2 = (i_wen && (i_waddr == i_raddr2)) ? i_wdata : r_regs[i_raddr2];
        end
    end

    // Flattened image from registered state only (no bypass), x0 slot forced to 0
    always_comb begin
        o_flat = '0;
        for (int k = 1; k < NREG; k++) begin
            o_flat[k*XLEN +: XLEN] = r_regs[k];
        end
    end

endmodule

// File: rtl/wb_commit_rf.sv
// Write-back/commit stage: retires one instruction per cycle, updates the
// register file, publishes commit information for the DPI model and halts
// after an ebreak so the model samples a frozen architectural state.
module wb_commit_rf
    import npc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    wb_commit_rf_if.slave        wb,
    input  logic [4:0]           rs1_addr,
    input  logic [4:0]           rs2_addr,
    output logic [XLEN-1:0]      rs1_data,
    output logic [XLEN-1:0]      rs2_data,
    output logic                 commit_valid,
    output logic [XLEN-1:0]      commit_pc,
    output logic [31:0]          commit_inst,
    output logic [63:0]          commit_cnt,
    output logic                 is_break,
    output logic [RF_FLAT_W-1:0] rf_flat,
    output commit_state_e        dbg_state
);

    commit_state_e   r_state;
    logic            r_ready;
    logic            r_commit_valid;
    logic [XLEN-1:0] r_commit_pc;
    logic [31:0]     r_commit_inst;
    logic [63:0]     r_commit_cnt;
    logic            r_is_break;

    logic            w_fire;
    logic            w_is_ebreak;
    logic            w_rf_we;

    assign w_fire      = wb.wb_valid & r_ready;
    assign w_is_ebreak = (wb.wb_inst == EBREAK_INST);
    // The ebreak itself never writes a GPR; reset in the same cycle wins over a write
    assign w_rf_we     = w_fire & wb.wb_wen & ~w_is_ebreak & ~rst;

    // Commit FSM with registered ready and commit outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= RUN;
            r_ready        <= 1'b1;
            r_commit_valid <= 1'b0;
            r_commit_pc    <= '0;
            r_commit_inst  <= '0;
            r_commit_cnt   <= '0;
            r_is_break     <= 1'b0;
        end else begin
            r_commit_valid <= w_fire;
            if (w_fire) begin
                r_commit_pc   <= wb.wb_pc;
                r_commit_inst <= wb.wb_inst;
                r_commit_cnt  <= r_commit_cnt + 64'd1;
            end
            case (r_state)
                RUN: begin
                    if (w_fire && w_is_ebreak) begin
                        r_state    <= HALT;
                        r_ready    <= 1'b0;
                        r_is_break <= 1'b1;
                    end
                end
                HALT: begin
                    r_ready <= 1'b0;
                end
                default: begin
                    r_state <= RUN;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    rf_2r1w u_rf (
        .clk      (clk),
        .rst      (rst),
        .i_wen    (w_rf_we),
        .i_waddr  (wb.wb_rd),
        .i_wdata  (wb.wb_wdata),
        .i_raddr1 (rs1_addr),
        .i_raddr2 (rs2_addr),
        .o_rdata1 (rs1_data),
        .o_rdata2 (rs2_data),
        .o_flat   (rf_flat)
    );

    assign wb.wb_ready   = r_ready;
    assign commit_valid  = r_commit_valid;
    assign commit_pc     = r_commit_pc;
    assign commit_inst   = r_commit_inst;
    assign commit_cnt    = r_commit_cnt;
    assign is_break      = r_is_break;
    assign dbg_state     = r_state;

endmodule

// File: doc/wb_commit_rf.md
Name: wb_commit_rf

Overview:
- Write-back/commit stage of the NPC core: accepts one retiring instruction per cycle over a valid/ready handshake.
- Updates the 32x64 architectural register file and provides two decode read ports.
- Publishes the committed PC/instruction, a retire counter, the flattened register state and a sticky is_break flag to the downstream DPI simulation model.
- After an ebreak retires, the stage stops accepting instructions so the model samples a frozen architectural state.

Parameters:
XLEN, 64, data/PC width
NREG, 32, number of GPRs; x0 hardwired to zero
EBREAK_INST, 32'h00100073, encoding that triggers halt

Ports:
clk  in  1  core clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
wb_valid  in  1  upstream has a retiring instruction
wb_ready  out  1  stage can accept (1 in RUN, 0 in HALT)
wb_pc  in  XLEN  PC of retiring instruction
wb_inst  in  32  instruction word
wb_wen  in  1  instruction writes rd
wb_rd  in  5  destination register index
wb_wdata  in  XLEN  write-back value
rs1_addr  in  5  decode read port 1 index
rs2_addr  in  5  decode read port 2 index
rs1_data  out  XLEN  read data 1 (combinational)
rs2_data  out  XLEN  read data 2 (combinational)
commit_valid  out  1  one-cycle pulse: an instruction retired last cycle
commit_pc  out  XLEN  PC of last retired instruction
commit_inst  out  32  instruction word of last retired instruction
commit_cnt  out  64  total retired instructions
is_break  out  1  sticky; ebreak has retired
rf_flat  out  NREG*XLEN  register k at bits [64k+63:64k]; bits of x0 always 0

Behaviour:
- fire = wb_valid & wb_ready.
- FSM states RUN, HALT.
  - RUN -> HALT on fire with wb_inst == EBREAK_INST.
  - HALT holds until rst.
  - rst in either state -> RUN.
- Reset (synchronous; sampled on the clock edge with rst=1) clears:
  - all GPRs, commit_valid, commit_pc, commit_inst, commit_cnt and is_break to 0;
  - wb_ready is 1 from the first cycle after reset.
- Register write: on a fire edge with wb_wen=1, wb_rd!=0 and wb_inst!=EBREAK_INST, rf[wb_rd] <= wb_wdata.
  - Writes to x0 are discarded.
  - No write occurs while in HALT, because fire is 0.
- Read ports:
  - index 0 returns 0;
  - otherwise return rf[idx], except write-first bypass: in the same cycle as a qualifying write with wb_rd==idx, return wb_wdata.
- Commit outputs, registered with latency 1:
  - commit_valid <= fire;
  - commit_pc and commit_inst load on fire and hold otherwise;
  - commit_cnt increments by 1 on fire and wraps from 2^64-1 to 0.
- is_break:
  - set on the edge that retires an ebreak, so it rises in the same cycle as that ebreak's commit_valid pulse;
  - stays 1 until rst.
- rf_flat is driven from the registered state. It reflects a write in the same cycle that commit_valid pulses for it, so the DPI model sees PC, instruction and GPRs consistent in one cycle.
- Back-to-back: fire on consecutive cycles is legal. Each fire gives exactly one commit_valid cycle, so a stream of N fires gives N consecutive pulses.
- wb_valid while in HALT: input ignored; wb_ready=0 and state unchanged.
- rst asserted in the same cycle as fire: reset wins; no write, no counter increment.

Decomposition:
- Shared package npc_pkg holds:
  - XLEN, NREG, EBREAK_INST;
  - the commit FSM state enum (RUN, HALT);
  - the localparam for the rf_flat width.
- One natural sub-module: rf_2r1w, the 32x64 register array with 2 combinational read ports, 1 write port, x0 tie-off and write-first bypass.
- wb_commit_rf holds the FSM, the commit registers, the counter and the flattening.

Test Plan:
- Reset, then idle -> wb_ready=1, is_break=0, commit_cnt=0, rf_flat all 0, rs1_data=rs2_data=0.
- fire wen=1 rd=5 wdata=64'hDEAD_BEEF_0000_0001 pc=64'h8000_0000 ->
  - the same cycle, rs1_addr=5 gives the wdata (bypass);
  - next cycle: commit_valid=1, commit_pc=64'h8000_0000, rf_flat[383:320]=wdata, commit_cnt=1.
- fire wen=1 rd=0 wdata=64'h1234 -> rf_flat[63:0] stays 0; rs1_addr=0 reads 0; commit_cnt increments.
- 3 back-to-back fires (rd=1,2,3), then ebreak (00100073) with wb_valid held high afterwards ->
  - 4 consecutive commit_valid pulses;
  - is_break rises with the 4th pulse;
  - wb_ready=0 afterwards; further inputs cause no writes; commit_cnt=4 frozen.
- In HALT, assert rst one cycle -> next cycle is_break=0, wb_ready=1, all GPRs 0, commit_cnt=0.
- Force commit_cnt to 64'hFFFF_FFFF_FFFF_FFFF via preload, then one fire -> commit_cnt=0.
